iommu_reg_dw_conv: RTL and testbench

Register-interface data-width converter between the AXI-Lite-to-RegIF bridge and a 32-bit IOMMU register map. It accepts 64-bit register-bus requests and executes each as two sequential 32-bit accesses (lower word, then upper word). It merges the two read words and error flags into one 64-bit response. This lets 64-bit IOMMU registers (capabilities, ddtp, queue bases) be reached by 64-bit software accesses while the register file stays 32-bit.

---
 rtl/iommu_reg_dw_conv.sv | 194 +++++++++++++++++++
 tb/tb_iommu_reg_dw_conv.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iommu_reg_dw_conv.sv
`default_nettype none
// ============================================================================
// Module      : iommu_reg_dw_conv
// Description : Register-bus data-width converter. Each 64-bit upstream
//               request becomes two sequential 32-bit downstream accesses
//               (lower word at base|0x0, then upper word at base|0x4). The
//               two read words and error flags are merged into one 64-bit
//               response pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : ADDR_WIDTH - register-bus address width (both ports)
// Ports       : clk_i, rst_ni          - clock, async active-low reset
//               s_valid_i/s_write_i/s_addr_i/s_wdata_i/s_wstrb_i
//                                      - 64-bit upstream request
//               s_ready_o/s_rdata_o/s_error_o
//                                      - one-cycle upstream completion
//               m_valid_o/m_write_o/m_addr_o/m_wdata_o/m_wstrb_o
//                                      - 32-bit downstream request
//               m_rdata_i/m_error_i/m_ready_i
//                                      - downstream completion
// Option      : IOMMU_REGCONV_SKIP_EMPTY_EN - when defined, write halves
//               with all-zero strobes are not issued downstream.
// ============================================================================
module iommu_reg_dw_conv #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  s_valid_i,
    input  logic                  s_write_i,
    input  logic [ADDR_WIDTH-1:0] s_addr_i,
    input  logic [63:0]           s_wdata_i,
    input  logic [7:0]            s_wstrb_i,
    output logic                  s_ready_o,
    output logic [63:0]           s_rdata_o,
    output logic                  s_error_o,
    output logic                  m_valid_o,
    output logic                  m_write_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [31:0]           m_wdata_o,
    output logic [3:0]            m_wstrb_o,
    input  logic [31:0]           m_rdata_i,
    input  logic                  m_error_i,
    input  logic                  m_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_write;
    logic [ADDR_WIDTH-1:3]   r_base;
    logic [31:0]             r_wdata_hi;
    logic [3:0]              r_wstrb_hi;
    logic [31:0]             r_rdata_lo;
    logic                    r_err;

    logic                    r_s_ready;
    logic [63:0]             r_s_rdata;
    logic                    r_s_error;
    logic                    r_m_valid;
    logic                    r_m_write;
    logic [ADDR_WIDTH-1:0]   r_m_addr;
    logic [31:0]             r_m_wdata;
    logic [3:0]              r_m_wstrb;

    // Half-skip decisions: the *_req forms look at the incoming request
    // (used in IDLE), w_skip_hi_lat looks at the latched request (used in LO).
    logic w_skip_lo_req;
    logic w_skip_hi_req;
    logic w_skip_hi_lat;

`ifdef IOMMU_REGCONV_SKIP_EMPTY_EN
    assign w_skip_lo_req = s_write_i && (s_wstrb_i[3:0] == 4'h0);
    assign w_skip_hi_req = s_write_i && (s_wstrb_i[7:4] == 4'h0);
    assign w_skip_hi_lat = r_write   && (r_wstrb_hi    == 4'h0);
`else
    assign w_skip_lo_req = 1'b0;
    assign w_skip_hi_req = 1'b0;
    assign w_skip_hi_lat = 1'b0;
`endif

    // Sub-word address bits carry no meaning; narrow accesses use strobes.
    logic w_unused;
    assign w_unused = ^s_addr_i[2:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_base     <= '0;
            r_wdata_hi <= 32'h0;
            r_wstrb_hi <= 4'h0;
            r_rdata_lo <= 32'h0;
            r_err      <= 1'b0;
            r_s_ready  <= 1'b0;
            r_s_rdata  <= 64'h0;
            r_s_error  <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_write  <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= 32'h0;
            r_m_wstrb  <= 4'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_valid_i && !r_s_ready) begin
                        r_write    <= s_write_i;
                        r_base     <= s_addr_i[ADDR_WIDTH-1:3];
                        r_wdata_hi <= s_wdata_i[63:32];
                        r_wstrb_hi <= s_wstrb_i[7:4];
                        r_rdata_lo <= 32'h0;
                        r_err      <= 1'b0;
                        r_m_write  <= s_write_i;
                        if (!w_skip_lo_req) begin
                            r_m_valid <= 1'b1;
                            r_m_addr  <= {s_addr_i[ADDR_WIDTH-1:3], 3'b000};
                            r_m_wdata <= s_wdata_i[31:0];
                            r_m_wstrb <= s_wstrb_i[3:0];
                            r_state   <= ST_LO;
                        end else if (!w_skip_hi_req) begin
                            r_m_valid <= 1'b1;
                            r_m_addr  <= {s_addr_i[ADDR_WIDTH-1:3], 3'b100};
                            r_m_wdata <= s_wdata_i[63:32];
                            r_m_wstrb <= s_wstrb_i[7:4];
                            r_state   <= ST_HI;
                        end else begin
                            // Fully empty write: answer without any access.
                            r_s_ready <= 1'b1;
                            r_s_rdata <= 64'h0;
                            r_s_error <= 1'b0;
                            r_state   <= ST_RESP;
                        end
                    end
                end
                ST_LO: begin
                    if (m_ready_i) begin
                        if (!r_write) begin
                            r_rdata_lo <= m_rdata_i;
                        end
                        r_err <= r_err | m_error_i;
                        if (!w_skip_hi_lat) begin
                            // m_valid stays high; fields switch to the upper half.
                            r_m_addr  <= {r_base, 3'b100};
                            r_m_wdata <= r_wdata_hi;
                            r_m_wstrb <= r_wstrb_hi;
                            r_state   <= ST_HI;
                        end else begin
                            r_m_valid <= 1'b0;
                            r_s_ready <= 1'b1;
                            r_s_rdata <= 64'h0;
                            r_s_error <= r_err | m_error_i;
                            r_state   <= ST_RESP;
                        end
                    end
                end
                ST_HI: begin
                    if (m_ready_i) begin
                        r_m_valid <= 1'b0;
                        r_err     <= r_err | m_error_i;
                        r_s_ready <= 1'b1;
                        r_s_rdata <= r_write ? 64'h0 : {m_rdata_i, r_rdata_lo};
                        r_s_error <= r_err | m_error_i;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_s_ready <= 1'b0;
                    r_s_rdata <= 64'h0;
                    r_s_error <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready_o = r_s_ready;
    assign s_rdata_o = r_s_rdata;
    assign s_error_o = r_s_error;
    assign m_valid_o = r_m_valid;
    assign m_write_o = r_m_write;
    assign m_addr_o  = r_m_addr;
    assign m_wdata_o = r_m_wdata;
    assign m_wstrb_o = r_m_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_iommu_reg_dw_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_iommu_reg_dw_conv
// Description : Directed self-checking bench for iommu_reg_dw_conv. Inputs
//               are driven and outputs sampled on the falling clock edge.
//               Cycle 0 is the cycle in which s_valid_i is first high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iommu_reg_dw_conv;

    localparam int AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          s_valid_i;
    logic          s_write_i;
    logic [AW-1:0] s_addr_i;
    logic [63:0]   s_wdata_i;
    logic [7:0]    s_wstrb_i;
    logic          s_ready_o;
    logic [63:0]   s_rdata_o;
    logic          s_error_o;
    logic          m_valid_o;
    logic          m_write_o;
    logic [AW-1:0] m_addr_o;
    logic [31:0]   m_wdata_o;
    logic [3:0]    m_wstrb_o;
    logic [31:0]   m_rdata_i;
    logic          m_error_i;
    logic          m_ready_i;

    // Downstream model: separate data/error for the lower and upper word.
    logic [31:0]   rd_lo;
    logic [31:0]   rd_hi;
    logic          err_lo;
    logic          err_hi;
    logic          ready_en;

    assign m_rdata_i = m_addr_o[2] ? rd_hi  : rd_lo;
    assign m_error_i = m_addr_o[2] ? err_hi : err_lo;
    assign m_ready_i = ready_en;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    iommu_reg_dw_conv #(.ADDR_WIDTH(AW)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .s_valid_i (s_valid_i),
        .s_write_i (s_write_i),
        .s_addr_i  (s_addr_i),
        .s_wdata_i (s_wdata_i),
        .s_wstrb_i (s_wstrb_i),
        .s_ready_o (s_ready_o),
        .s_rdata_o (s_rdata_o),
        .s_error_o (s_error_o),
        .m_valid_o (m_valid_o),
        .m_write_o (m_write_o),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_wstrb_o (m_wstrb_o),
        .m_rdata_i (m_rdata_i),
        .m_error_i (m_error_i),
        .m_ready_i (m_ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic chk_m(input string tag, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        chk({tag, ".m_valid"}, {63'h0, m_valid_o}, {63'h0, v});
        chk({tag, ".m_write"}, {63'h0, m_write_o}, {63'h0, w});
        chk({tag, ".m_addr"},  {32'h0, m_addr_o},  {32'h0, a});
        chk({tag, ".m_wdata"}, {32'h0, m_wdata_o}, {32'h0, d});
        chk({tag, ".m_wstrb"}, {60'h0, m_wstrb_o}, {60'h0, s});
    endtask

    task automatic chk_s(input string tag, input logic r, input logic [63:0] d, input logic e);
        chk({tag, ".s_ready"}, {63'h0, s_ready_o}, {63'h0, r});
        chk({tag, ".s_rdata"}, s_rdata_o, d);
        chk({tag, ".s_error"}, {63'h0, s_error_o}, {63'h0, e});
    endtask

    task automatic chk_all_zero(input string tag);
        chk_s(tag, 1'b0, 64'h0, 1'b0);
        chk_m(tag, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        s_valid_i = 1'b1;
        s_write_i = w;
        s_addr_i  = a;
        s_wdata_i = d;
        s_wstrb_i = s;
    endtask

    initial begin
        rst_ni    = 1'b0;
        s_valid_i = 1'b0;
        s_write_i = 1'b0;
        s_addr_i  = '0;
        s_wdata_i = 64'h0;
        s_wstrb_i = 8'h0;
        rd_lo     = 32'h0;
        rd_hi     = 32'h0;
        err_lo    = 1'b0;
        err_hi    = 1'b0;
        ready_en  = 1'b1;

        next_cycle();
        next_cycle();
        chk_all_zero("reset");
        rst_ni = 1'b1;
        next_cycle();
        chk_all_zero("idle_after_reset");

        // 1) 64-bit read at 0x18, zero-wait downstream.
        rd_lo = 32'hAAAA5555;
        rd_hi = 32'h12345678;
        req(1'b0, 32'h18, 64'h0, 8'hFF);                    // cycle 0
        next_cycle();                                       // cycle 1
        chk_m("rd.c1", 1'b1, 1'b0, 32'h18, 32'h0, 4'hF);
        chk_s("rd.c1", 1'b0, 64'h0, 1'b0);
        next_cycle();                                       // cycle 2
        chk_m("rd.c2", 1'b1, 1'b0, 32'h1C, 32'h0, 4'hF);
        chk_s("rd.c2", 1'b0, 64'h0, 1'b0);
        next_cycle();                                       // cycle 3
        chk("rd.c3.m_valid", {63'h0, m_valid_o}, 64'h0);
        chk_s("rd.c3", 1'b1, 64'h12345678AAAA5555, 1'b0);
        s_valid_i = 1'b0;
        next_cycle();
        chk_s("rd.c4", 1'b0, 64'h0, 1'b0);

        // 2) Full write at 0x20; s_valid dropped early, transaction still completes.
        req(1'b1, 32'h20, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        next_cycle();
        chk_m("wr.c1", 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        s_valid_i = 1'b0;
        next_cycle();
        chk_m("wr.c2", 1'b1, 1'b1, 32'h24, 32'hDEADBEEF, 4'hF);
        next_cycle();
        chk_s("wr.c3", 1'b1, 64'h0, 1'b0);
        next_cycle();
        chk_s("wr.c4", 1'b0, 64'h0, 1'b0);
        chk("wr.c4.m_valid", {63'h0, m_valid_o}, 64'h0);

        // 3) Read at 0x30 with two wait cycles per half.
        rd_lo    = 32'h0BADF00D;
        rd_hi    = 32'h76543210;
        ready_en = 1'b0;
        req(1'b0, 32'h37, 64'h0, 8'hFF);                    // low bits ignored
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            chk_m($sformatf("wait.lo.c%0d", c), 1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
            chk("wait.lo.s_ready", {63'h0, s_ready_o}, 64'h0);
            if (c == 3) ready_en = 1'b1;
        end
        for (int c = 4; c <= 6; c++) begin
            next_cycle();
            ready_en = 1'b0;
            chk_m($sformatf("wait.hi.c%0d", c), 1'b1, 1'b0, 32'h34, 32'h0, 4'hF);
            chk("wait.hi.s_ready", {63'h0, s_ready_o}, 64'h0);
            if (c == 6) ready_en = 1'b1;
        end
        next_cycle();                                       // cycle 7
        chk_s("wait.c7", 1'b1, 64'h76543210_0BADF00D, 1'b0);
        s_valid_i = 1'b0;
        next_cycle();
        chk_s("wait.c8", 1'b0, 64'h0, 1'b0);

        // 4) Error on the lower half only: upper half still issued, error merged.
        err_lo = 1'b1;
        req(1'b0, 32'h40, 64'h0, 8'hFF);
        next_cycle();
        chk_m("err.c1", 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        next_cycle();
        chk_m("err.c2", 1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
        next_cycle();
        chk_s("err.c3", 1'b1, 64'h76543210_0BADF00D, 1'b1);
        s_valid_i = 1'b0;
        err_lo    = 1'b0;
        next_cycle();
        chk_s("err.c4", 1'b0, 64'h0, 1'b0);

        // 4b) Error on the upper half only.
        err_hi = 1'b1;
        req(1'b0, 32'h48, 64'h0, 8'hFF);
        next_cycle();
        next_cycle();
        next_cycle();
        chk_s("errhi.c3", 1'b1, 64'h76543210_0BADF00D, 1'b1);
        s_valid_i = 1'b0;
        err_hi    = 1'b0;
        next_cycle();

        // 5) Upper-only write at 0x08.
        req(1'b1, 32'h08, 64'h11112222_33334444, 8'hF0);
        next_cycle();
`ifdef IOMMU_REGCONV_SKIP_EMPTY_EN
        chk_m("skip.c1", 1'b1, 1'b1, 32'h0C, 32'h11112222, 4'hF);
        next_cycle();
        chk_s("skip.c2", 1'b1, 64'h0, 1'b0);
`else
        chk_m("skip.c1", 1'b1, 1'b1, 32'h08, 32'h33334444, 4'h0);
        next_cycle();
        chk_m("skip.c2", 1'b1, 1'b1, 32'h0C, 32'h11112222, 4'hF);
        chk("skip.c2.s_ready", {63'h0, s_ready_o}, 64'h0);
        next_cycle();
        chk_s("skip.c3", 1'b1, 64'h0, 1'b0);
`endif
        s_valid_i = 1'b0;
        next_cycle();
        chk_s("skip.end", 1'b0, 64'h0, 1'b0);

        // 6) Asynchronous reset while the upper half is pending.
        rd_lo    = 32'h55555555;
        rd_hi    = 32'h66666666;
        req(1'b0, 32'h50, 64'h0, 8'hFF);
        next_cycle();                                       // LO, accepted at next edge
        ready_en = 1'b1;
        next_cycle();                                       // HI
        ready_en = 1'b0;
        chk_m("rst.hi", 1'b1, 1'b0, 32'h54, 32'h0, 4'hF);
        rst_ni = 1'b0;
        #1;
        chk_all_zero("rst.async");
        s_valid_i = 1'b0;
        next_cycle();
        rst_ni   = 1'b1;
        ready_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            chk_s($sformatf("rst.quiet%0d", c), 1'b0, 64'h0, 1'b0);
            chk("rst.quiet.m_valid", {63'h0, m_valid_o}, 64'h0);
        end

        // New read after reset completes normally.
        req(1'b0, 32'h60, 64'h0, 8'hFF);
        next_cycle();
        chk_m("post.c1", 1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
        next_cycle();
        chk_m("post.c2", 1'b1, 1'b0, 32'h64, 32'h0, 4'hF);
        next_cycle();
        chk_s("post.c3", 1'b1, 64'h66666666_55555555, 1'b0);
        s_valid_i = 1'b0;
        next_cycle();
        chk_s("post.c4", 1'b0, 64'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
